// File: rtl/sc_deser_pkg.sv
// Shared state encoding and sizing helper for the serial deserializer.
package sc_deser_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] SHIFT = 2'd1;
   localparam logic [STATE_W-1:0] LOAD  = 2'd2;
   localparam logic [STATE_W-1:0] ABORT = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_LOAD  = LOAD,
      ST_ABORT = ABORT
   } deser_state_e;

   // Bit counter must reach DATAWIDTH itself when a parity bit trails the word.
   function automatic int count_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/sc_deser_timeout_counter.sv
// Saturating idle-cycle counter; tc_o flags the cycle whose edge brings the
// count up to DESER_TIMEOUT.
module sc_deser_timeout_counter #(
   parameter int DESER_TIMEOUT    = 255,
   parameter int DESER_TIMERWIDTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam logic [DESER_TIMERWIDTH-1:0] TC_MAX  = DESER_TIMERWIDTH'(DESER_TIMEOUT);
   localparam logic [DESER_TIMERWIDTH-1:0] TC_LAST = DESER_TIMERWIDTH'(DESER_TIMEOUT - 1);

   logic [DESER_TIMERWIDTH-1:0] count_q;
   logic [DESER_TIMERWIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != TC_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = enable_i && !clear_i && (count_q == TC_LAST);

endmodule

// File: rtl/sc_serial_deserializer.sv
// Serial-to-parallel word assembler with load/clear pulses for a downstream
// register. Define SC_DESER_PARITY_EN to append and check an even-parity bit.
//
// state  | meaning
// IDLE   | waiting for start; bit strobes ignored
// SHIFT  | collecting bits MSB-first, idle timer running between strobes
// LOAD   | one cycle: completed word on data bus, load pulse high
// ABORT  | one cycle: clear pulse high, frame error set
module sc_serial_deserializer
   import sc_deser_pkg::*;
#(
   parameter int DESER_DATAWIDTH  = 8,
   parameter int DESER_TIMEOUT    = 255,
   parameter int DESER_TIMERWIDTH = 8
) (
   input  logic                       SC_DESER_CLOCK_50,
   input  logic                       SC_DESER_RESET_InHigh,
   input  logic                       SC_DESER_start_In,
   input  logic                       SC_DESER_bit_In,
   input  logic                       SC_DESER_bitValid_In,
   output logic [DESER_DATAWIDTH-1:0] SC_DESER_data_OutBUS,
   output logic                       SC_DESER_load_Out,
   output logic                       SC_DESER_clear_Out,
   output logic                       SC_DESER_busy_Out,
   output logic                       SC_DESER_frameErr_Out
);

   localparam int CNT_W = count_width(DESER_DATAWIDTH);
`ifdef SC_DESER_PARITY_EN
   localparam int FRAME_BITS = DESER_DATAWIDTH + 1;
`else
   localparam int FRAME_BITS = DESER_DATAWIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

   deser_state_e               state_q;
   logic [DESER_DATAWIDTH-1:0] shreg_q;
   logic [CNT_W-1:0]           count_q;
   logic [DESER_DATAWIDTH-1:0] data_q;
   logic                       load_q;
   logic                       clear_q;
   logic                       busy_q;
   logic                       frame_err_q;

   logic timer_clear;
   logic timer_en;
   logic timer_tc;

   // A restart or a received bit zeroes the idle timer.
   assign timer_en    = (state_q == ST_SHIFT) && !SC_DESER_bitValid_In && !SC_DESER_start_In;
   assign timer_clear = (state_q != ST_SHIFT) || SC_DESER_bitValid_In || SC_DESER_start_In;

   sc_deser_timeout_counter #(
      .DESER_TIMEOUT    (DESER_TIMEOUT),
      .DESER_TIMERWIDTH (DESER_TIMERWIDTH)
   ) u_timeout (
      .clk_i    (SC_DESER_CLOCK_50),
      .rst_i    (SC_DESER_RESET_InHigh),
      .clear_i  (timer_clear),
      .enable_i (timer_en),
      .tc_o     (timer_tc)
   );

   always_ff @(posedge SC_DESER_CLOCK_50 or posedge SC_DESER_RESET_InHigh) begin
      if (SC_DESER_RESET_InHigh) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         count_q     <= '0;
         data_q      <= '0;
         load_q      <= 1'b0;
         clear_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         load_q  <= 1'b0;
         clear_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (SC_DESER_start_In) begin
                  state_q     <= ST_SHIFT;
                  shreg_q     <= '0;
                  count_q     <= '0;
                  frame_err_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (SC_DESER_start_In) begin
                  shreg_q     <= '0;
                  count_q     <= '0;
                  frame_err_q <= 1'b1;
               end else if (SC_DESER_bitValid_In) begin
                  if (count_q == LAST_IDX) begin
                     count_q <= '0;
`ifdef SC_DESER_PARITY_EN
                     if ((^shreg_q) == SC_DESER_bit_In) begin
                        state_q <= ST_LOAD;
                        data_q  <= shreg_q;
                        load_q  <= 1'b1;
                     end else begin
                        state_q     <= ST_ABORT;
                        clear_q     <= 1'b1;
                        frame_err_q <= 1'b1;
                     end
`else
                     state_q <= ST_LOAD;
                     data_q  <= {shreg_q[DESER_DATAWIDTH-2:0], SC_DESER_bit_In};
                     load_q  <= 1'b1;
`endif
                  end else begin
                     shreg_q <= {shreg_q[DESER_DATAWIDTH-2:0], SC_DESER_bit_In};
                     count_q <= count_q + 1'b1;
                  end
               end else if (timer_tc) begin
                  state_q     <= ST_ABORT;
                  count_q     <= '0;
                  clear_q     <= 1'b1;
                  frame_err_q <= 1'b1;
               end
            end
            ST_LOAD, ST_ABORT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign SC_DESER_data_OutBUS  = data_q;
   assign SC_DESER_load_Out     = load_q;
   assign SC_DESER_clear_Out    = clear_q;
   assign SC_DESER_busy_Out     = busy_q;
   assign SC_DESER_frameErr_Out = frame_err_q;

endmodule

// File: doc/sc_serial_deserializer.md
Name: sc_serial_deserializer

Overview:
- Upstream feeder for the general-purpose parallel register.
- Assembles a DESER_DATAWIDTH-bit word from a strobed serial bit stream.
- Presents the word on a parallel bus with a one-cycle active-high load pulse.
- On an aborted frame, issues a one-cycle active-high clear pulse instead, which zeroes the downstream register.

Parameters:
- DESER_DATAWIDTH, 8: word width in bits; must be >= 2.
- DESER_TIMEOUT, 255: maximum consecutive idle cycles (no bit strobe) tolerated mid-frame before abort; must be >= 1.
- DESER_TIMERWIDTH, 8: timer counter width; must hold DESER_TIMEOUT.

Ports:
- SC_DESER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_DESER_RESET_InHigh  in  1  reset; asynchronous, active-high.
- SC_DESER_start_In  in  1  frame start strobe, one cycle.
- SC_DESER_bit_In  in  1  serial data bit; sampled only when the bit strobe is high.
- SC_DESER_bitValid_In  in  1  bit strobe; at most one bit per cycle.
- SC_DESER_data_OutBUS  out  DESER_DATAWIDTH  last completed word; held between loads.
- SC_DESER_load_Out  out  1  one-cycle pulse; data_OutBUS is valid in this cycle.
- SC_DESER_clear_Out  out  1  one-cycle pulse on abort.
- SC_DESER_busy_Out  out  1  high whenever the state is not IDLE.
- SC_DESER_frameErr_Out  out  1  sticky abort flag; cleared by the next accepted start.

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE; clears shift register, bit counter, timer, data_OutBUS and all 1-bit outputs to 0. Reset mid-frame discards the partial word with no clear pulse.
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- State IDLE:
  - bitValid is ignored.
  - start -> SHIFT; shift register := 0, count := 0, timer := 0, frameErr := 0.
- State SHIFT:
  - bitValid=1: shift MSB-first (shreg := {shreg[W-2:0], bit}); count++; timer := 0.
  - Bit with count == W-1 (last bit) -> LOAD.
  - bitValid=0: timer++. When timer reaches DESER_TIMEOUT -> ABORT, on that same edge.
  - start in SHIFT: restart the frame (shreg, count, timer := 0) and set frameErr := 1; no clear pulse. start has priority over a simultaneous bitValid, whose bit is discarded.
- State LOAD (1 cycle):
  - data_OutBUS := completed word and load_Out = 1 in the same cycle; then -> IDLE.
  - start is ignored.
- State ABORT (1 cycle):
  - clear_Out = 1 and frameErr := 1; then -> IDLE.
  - data_OutBUS is unchanged.
  - start is ignored.
- Latency: load_Out rises exactly one cycle after the edge that samples the last bit. Minimum frame is W+2 cycles from start to the return to IDLE.
- load_Out and clear_Out are never high together, and never high for two consecutive cycles.
- busy_Out = 1 in SHIFT, LOAD and ABORT. Upstream must hold start until busy_Out = 0; starts issued in LOAD or ABORT are lost.
- Timer saturates and never wraps; the count wraps only via the LOAD transition.

Optional Feature:
- Macro: SC_DESER_PARITY_EN.
- Defined:
  - After W data bits, SHIFT expects one extra even-parity bit, so the frame is W+1 bits.
  - Parity match -> LOAD.
  - Mismatch -> ABORT (clear pulse, frameErr set).
  - The parity bit is not stored in data_OutBUS.
- Undefined: the frame is exactly W bits with no parity check.

Decomposition:
- Package sc_deser_pkg:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2, ABORT=2'd3) and state width 2.
  - helper function returning the count width, clog2(DESER_DATAWIDTH+1).
- One sub-module, sc_deser_timeout_counter: saturating idle-cycle counter with synchronous clear, enable, and terminal-count output compared against DESER_TIMEOUT.
- FSM, shift register and output registers stay in the top module.

Test Plan:
- Reset: assert reset for 3 cycles mid-SHIFT -> all outputs 0, state IDLE; release, start, bits 1,0,1,0,0,1,0,1 -> data_OutBUS=8'hA5, load_Out high exactly 1 cycle, one cycle after the 8th bit.
- Gapped bits: W=8, TIMEOUT=4; bits of 8'h3C with 3 idle cycles between each -> load with 8'h3C, no clear, frameErr=0.
- Timeout: TIMEOUT=4; start, 3 bits, then 4 idle cycles -> clear_Out pulse 1 cycle, frameErr=1, data_OutBUS keeps its previous value (8'h3C), busy falls the next cycle.
- Restart and priority: start, 5 bits, then start together with bitValid -> frameErr=1, no clear; next 8 bits of 8'hFF -> load 8'hFF; the following start clears frameErr.
- Ignored inputs: bitValid pulses in IDLE and start during LOAD -> no state change, no extra load or clear pulses.
- With SC_DESER_PARITY_EN: 8'hA5 followed by parity 0 -> load 8'hA5; 8'hA5 followed by parity 1 -> clear pulse and frameErr=1.
